decode_queue: RTL and testbench

DECODE_QUEUE -- requirements
Module: decode_queue

---
 rtl/decode_queue.sv | 174 +++++++++++++++++
 tb/tb_decode_queue.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | decode_queue: RV32I(M) decoder feeding a DEPTH-entry FIFO of records |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
module decode_queue #(
  parameter int DEPTH = 4,
  parameter bit M_EXT = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_instr,
  input  logic [31:0]                in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [6:0]                 out_opcode,
  output logic [4:0]                 out_rd,
  output logic [2:0]                 out_funct3,
  output logic [4:0]                 out_rs1,
  output logic [4:0]                 out_rs2,
  output logic [6:0]                 out_funct7,
  output logic [31:0]                out_imm,
  output logic [2:0]                 out_imm_type,
  output logic [31:0]                out_pc,
  output logic                       out_illegal,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

  localparam logic [6:0] C_OP_LUI    = 7'b0110111;
  localparam logic [6:0] C_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] C_OP_JAL    = 7'b1101111;
  localparam logic [6:0] C_OP_JALR   = 7'b1100111;
  localparam logic [6:0] C_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] C_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] C_OP_STORE  = 7'b0100011;
  localparam logic [6:0] C_OP_IMM    = 7'b0010011;
  localparam logic [6:0] C_OP_OP     = 7'b0110011;
  localparam logic [6:0] C_OP_MISC   = 7'b0001111;
  localparam logic [6:0] C_OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] C_IMM_NONE = 3'd0;
  localparam logic [2:0] C_IMM_I    = 3'd1;
  localparam logic [2:0] C_IMM_S    = 3'd2;
  localparam logic [2:0] C_IMM_B    = 3'd3;
  localparam logic [2:0] C_IMM_U    = 3'd4;
  localparam logic [2:0] C_IMM_J    = 3'd5;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [2:0]  imm_type;
    logic        illegal;
  } rec_t;

  rec_t             r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;

  logic [6:0]  w_op;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic        w_legal;
  logic [2:0]  w_kind;
  logic [31:0] w_imm;
  rec_t        w_rec;
  rec_t        w_head;
  logic        w_push;
  logic        w_pop;

  assign w_op = in_instr[6:0];
  assign w_f3 = in_instr[14:12];
  assign w_f7 = in_instr[31:25];

  // Decode happens on the way in so the head entry drives outputs straight from storage.
  always_comb begin
    w_legal = 1'b0;
    w_kind  = C_IMM_NONE;
    case (w_op)
      C_OP_LUI, C_OP_AUIPC: begin w_legal = 1'b1; w_kind = C_IMM_U; end
      C_OP_JAL:    begin w_legal = 1'b1; w_kind = C_IMM_J; end
      C_OP_JALR:   begin w_legal = (w_f3 == 3'b000); w_kind = C_IMM_I; end
      C_OP_BRANCH: begin w_legal = (w_f3 != 3'b010) && (w_f3 != 3'b011); w_kind = C_IMM_B; end
      C_OP_LOAD:   begin
        w_legal = (w_f3 != 3'b011) && (w_f3 != 3'b110) && (w_f3 != 3'b111);
        w_kind  = C_IMM_I;
      end
      C_OP_STORE:  begin w_legal = (w_f3 < 3'b011); w_kind = C_IMM_S; end
      C_OP_IMM:    begin
        w_kind = C_IMM_I;
        if (w_f3 == 3'b001)      w_legal = (w_f7 == 7'b0000000);
        else if (w_f3 == 3'b101) w_legal = (w_f7 == 7'b0000000) || (w_f7 == 7'b0100000);
        else                     w_legal = 1'b1;
      end
      C_OP_OP:     begin
        w_legal = (w_f7 == 7'b0000000)
               || ((w_f7 == 7'b0100000) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)))
               || ((w_f7 == 7'b0000001) && M_EXT);
      end
      C_OP_MISC:   w_legal = 1'b1;
      C_OP_SYSTEM: begin w_legal = 1'b1; w_kind = C_IMM_I; end
      default:     w_legal = 1'b0;
    endcase
    if (!w_legal) w_kind = C_IMM_NONE;

    case (w_kind)
      C_IMM_I: w_imm = {{20{in_instr[31]}}, in_instr[31:20]};
      C_IMM_S: w_imm = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      C_IMM_B: w_imm = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
      C_IMM_U: w_imm = {in_instr[31:12], 12'b0};
      C_IMM_J: w_imm = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
      default: w_imm = 32'b0;
    endcase

    w_rec.instr    = in_instr;
    w_rec.pc       = in_pc;
    w_rec.imm      = w_imm;
    w_rec.imm_type = w_kind;
    w_rec.illegal  = !w_legal;
  end

  assign in_ready  = (r_count != C_FULL);
  assign out_valid = (r_count != '0);
  assign count     = r_count;
  assign w_push    = in_valid && in_ready && !flush;
  assign w_pop     = out_valid && out_ready && !flush;

  // Storage is data-only and needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_rec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_head       = r_mem[r_rptr];
  assign out_opcode   = w_head.instr[6:0];
  assign out_rd       = w_head.instr[11:7];
  assign out_funct3   = w_head.instr[14:12];
  assign out_rs1      = w_head.instr[19:15];
  assign out_rs2      = w_head.instr[24:20];
  assign out_funct7   = w_head.instr[31:25];
  assign out_imm      = w_head.imm;
  assign out_imm_type = w_head.imm_type;
  assign out_pc       = w_head.pc;
  assign out_illegal  = w_head.illegal;

endmodule
`default_nettype wire

// File: tb/tb_decode_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_decode_queue: scoreboard bench for decode_queue (M_EXT=0 and 1)   |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
module tb_decode_queue;

  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [2:0]  typ;
    logic        ill0;
    logic        ill1;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;

  logic in_ready, out_valid, out_illegal;
  logic [6:0] out_opcode, out_funct7;
  logic [4:0] out_rd, out_rs1, out_rs2;
  logic [2:0] out_funct3, out_imm_type;
  logic [31:0] out_imm, out_pc;
  logic [CW-1:0] count;

  logic m_in_ready, m_out_valid, m_out_illegal;
  logic [6:0] m_out_opcode, m_out_funct7;
  logic [4:0] m_out_rd, m_out_rs1, m_out_rs2;
  logic [2:0] m_out_funct3, m_out_imm_type;
  logic [31:0] m_out_imm, m_out_pc;
  logic [CW-1:0] m_count;

  int tests = 0;
  int fails = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  decode_queue #(.DEPTH(DEPTH), .M_EXT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_rd(out_rd), .out_funct3(out_funct3), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_funct7(out_funct7), .out_imm(out_imm), .out_imm_type(out_imm_type),
    .out_pc(out_pc), .out_illegal(out_illegal), .count(count)
  );

  decode_queue #(.DEPTH(DEPTH), .M_EXT(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(m_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(m_out_valid), .out_ready(out_ready),
    .out_opcode(m_out_opcode), .out_rd(m_out_rd), .out_funct3(m_out_funct3), .out_rs1(m_out_rs1),
    .out_rs2(m_out_rs2), .out_funct7(m_out_funct7), .out_imm(m_out_imm), .out_imm_type(m_out_imm_type),
    .out_pc(m_out_pc), .out_illegal(m_out_illegal), .count(m_count)
  );

  // Reference decoder written from the ISA encoding tables.
  function automatic exp_t ref_decode(input logic [31:0] i, input logic [31:0] pc);
    exp_t e;
    logic [2:0] f3;
    logic [6:0] f7;
    logic legal;
    logic mlegal;
    logic [2:0] k;
    f3 = i[14:12];
    f7 = i[31:25];
    legal = 1'b0;
    mlegal = 1'b0;
    k = 3'd0;
    case (i[6:0])
      7'h37, 7'h17: begin legal = 1; k = 4; end
      7'h6F: begin legal = 1; k = 5; end
      7'h67: begin legal = (f3 == 0); k = 1; end
      7'h63: begin legal = !(f3 == 2 || f3 == 3); k = 3; end
      7'h03: begin legal = !(f3 == 3 || f3 == 6 || f3 == 7); k = 1; end
      7'h23: begin legal = (f3 <= 2); k = 2; end
      7'h13: begin
        k = 1;
        legal = (f3 == 1) ? (f7 == 0) : (f3 == 5) ? (f7 == 0 || f7 == 7'h20) : 1'b1;
      end
      7'h33: begin
        legal = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
        mlegal = (f7 == 7'h01);
      end
      7'h0F: legal = 1;
      7'h73: begin legal = 1; k = 1; end
      default: legal = 0;
    endcase
    if (i[1:0] != 2'b11) legal = 0;
    if (!legal) k = 0;
    e.instr = i;
    e.pc = pc;
    e.typ = k;
    e.ill0 = !legal;
    e.ill1 = !(legal || mlegal);
    case (k)
      3'd1: e.imm = {{20{i[31]}}, i[31:20]};
      3'd2: e.imm = {{20{i[31]}}, i[31:25], i[11:7]};
      3'd3: e.imm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
      3'd4: e.imm = {i[31:12], 12'h000};
      3'd5: e.imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
      default: e.imm = 32'h0;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [12];
    logic [31:0] r;
    int sel;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73, 7'h2B};
    r = $urandom;
    r[6:0] = ops[$urandom_range(0, 11)];
    if (r[6:0] == 7'h33 || r[6:0] == 7'h13) begin
      sel = $urandom_range(0, 3);
      if (sel == 0) r[31:25] = 7'h00;
      else if (sel == 1) r[31:25] = 7'h20;
      else if (sel == 2) r[31:25] = 7'h01;
    end
    if ($urandom_range(0, 15) == 0) r[1:0] = 2'($urandom_range(0, 2));
    return r;
  endfunction

  // One clock: check against the model at negedge, advance the model at posedge.
  task automatic tick();
    bit push, pop;
    exp_t e;
    @(negedge clk);
    push = in_valid && (sb.size() != DEPTH);
    pop = out_ready && (sb.size() != 0);
    tests++;
    if (count !== CW'(sb.size())) begin fails++; $display("FAIL count: got %0d expected %0d", count, sb.size()); end
    tests++;
    if (m_count !== CW'(sb.size())) begin fails++; $display("FAIL m_count: got %0d expected %0d", m_count, sb.size()); end
    tests++;
    if (in_ready !== (sb.size() != DEPTH)) begin fails++; $display("FAIL in_ready: got %b expected %b", in_ready, sb.size() != DEPTH); end
    tests++;
    if (out_valid !== (sb.size() != 0)) begin fails++; $display("FAIL out_valid: got %b expected %b", out_valid, sb.size() != 0); end
    if (sb.size() != 0) begin
      e = sb[0];
      tests++;
      if ({out_funct7, out_rs2, out_rs1, out_funct3, out_rd, out_opcode} !== e.instr) begin
        fails++; $display("FAIL fields: got %h expected %h", {out_funct7, out_rs2, out_rs1, out_funct3, out_rd, out_opcode}, e.instr);
      end
      tests++;
      if (out_imm !== e.imm || out_imm_type !== e.typ) begin
        fails++; $display("FAIL imm: got %h/%0d expected %h/%0d (instr %h)", out_imm, out_imm_type, e.imm, e.typ, e.instr);
      end
      tests++;
      if (out_pc !== e.pc) begin fails++; $display("FAIL pc: got %h expected %h", out_pc, e.pc); end
      tests++;
      if (out_illegal !== e.ill0 || m_out_illegal !== e.ill1) begin
        fails++; $display("FAIL illegal: got %b/%b expected %b/%b (instr %h)", out_illegal, m_out_illegal, e.ill0, e.ill1, e.instr);
      end
    end
    @(posedge clk);
    if (flush) sb.delete();
    else begin
      if (pop) void'(sb.pop_front());
      if (push) sb.push_back(ref_decode(in_instr, in_pc));
    end
    #1;
  endtask

  task automatic idle_inputs();
    flush = 0; in_valid = 0; out_ready = 0; in_instr = 0; in_pc = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    #12;
    tests++;
    if (count !== 0 || out_valid !== 0 || in_ready !== 1) begin
      fails++; $display("FAIL reset: got cnt %0d ov %b ir %b expected 0 0 1", count, out_valid, in_ready);
    end
    @(posedge clk); #1 rst_n = 1;
    tick();
  endtask

  task automatic test_basic();
    in_valid = 1; in_instr = 32'hFFF00093; in_pc = 32'h100;
    tick();
    in_valid = 0;
    tests++;
    if (out_valid !== 1 || out_opcode !== 7'h13 || out_rd !== 5'd1 || out_rs1 !== 5'd0 ||
        out_imm !== 32'hFFFFFFFF || out_imm_type !== 3'd1 || out_illegal !== 0 || out_pc !== 32'h100) begin
      fails++; $display("FAIL addi_head: got v%b op%h rd%0d rs1%0d imm%h t%0d il%b pc%h expected v1 op13 rd1 rs10 immffffffff t1 il0 pc100",
                        out_valid, out_opcode, out_rd, out_rs1, out_imm, out_imm_type, out_illegal, out_pc);
    end
    out_ready = 1;
    tick();
    out_ready = 0;
  endtask

  task automatic test_imm();
    in_valid = 1; in_instr = 32'h00000463; in_pc = 32'h200; tick();
    in_instr = 32'h123452B7; in_pc = 32'h204; tick();
    in_valid = 0;
    tests++;
    if (out_imm !== 32'h8 || out_imm_type !== 3'd3) begin
      fails++; $display("FAIL branch_imm: got %h/%0d expected 00000008/3", out_imm, out_imm_type);
    end
    out_ready = 1; tick(); out_ready = 0;
    tests++;
    if (out_imm !== 32'h12345000 || out_imm_type !== 3'd4 || out_rd !== 5'd5) begin
      fails++; $display("FAIL lui_imm: got %h/%0d rd %0d expected 12345000/4 rd 5", out_imm, out_imm_type, out_rd);
    end
    out_ready = 1; tick(); out_ready = 0;
  endtask

  task automatic test_full();
    for (int k = 0; k < 5; k++) begin
      in_valid = 1; in_instr = 32'h00100013 + (k << 7); in_pc = 32'h300 + 4 * k; tick();
    end
    tests++;
    if (count !== CW'(4) || in_ready !== 0) begin
      fails++; $display("FAIL full: got cnt %0d ir %b expected 4 0", count, in_ready);
    end
    out_ready = 1;
    for (int k = 0; k < 4; k++) tick();
    in_valid = 0;
    for (int k = 0; k < 5; k++) tick();
    out_ready = 0;
  endtask

  task automatic test_illegal();
    in_valid = 1; in_instr = 32'h00000000; in_pc = 32'h400; tick();
    in_instr = 32'h02208033; in_pc = 32'h404; tick();
    in_valid = 0;
    tests++;
    if (out_illegal !== 1 || out_imm !== 0 || out_imm_type !== 0) begin
      fails++; $display("FAIL zero_word: got il %b imm %h t %0d expected 1 0 0", out_illegal, out_imm, out_imm_type);
    end
    out_ready = 1; tick(); out_ready = 0;
    tests++;
    if (out_illegal !== 1 || m_out_illegal !== 0) begin
      fails++; $display("FAIL mul_legal: got %b/%b expected 1/0", out_illegal, m_out_illegal);
    end
    out_ready = 1; tick(); out_ready = 0;
  endtask

  task automatic test_flush();
    in_valid = 1;
    for (int k = 0; k < 3; k++) begin in_instr = 32'h00000013 | (k << 15); in_pc = 32'h500 + 4 * k; tick(); end
    flush = 1; in_instr = 32'hDEADC0B7; in_pc = 32'h5FC; tick();
    flush = 0; in_valid = 0;
    tests++;
    if (count !== 0 || out_valid !== 0) begin
      fails++; $display("FAIL flush: got cnt %0d ov %b expected 0 0", count, out_valid);
    end
    in_valid = 1; in_instr = 32'h00A00513; in_pc = 32'h600; tick();
    in_valid = 0; out_ready = 1; tick(); tick(); out_ready = 0;
  endtask

  task automatic test_reset_mid();
    in_valid = 1; in_instr = 32'h0000006F; in_pc = 32'h700; tick();
    in_instr = 32'h00112023; in_pc = 32'h704; tick();
    in_valid = 0;
    #2 rst_n = 0;
    #1;
    tests++;
    if (count !== 0 || out_valid !== 0 || in_ready !== 1) begin
      fails++; $display("FAIL async_reset: got cnt %0d ov %b ir %b expected 0 0 1", count, out_valid, in_ready);
    end
    sb.delete();
    @(posedge clk); #1 rst_n = 1;
    in_valid = 1; in_instr = 32'h00C58593; in_pc = 32'h800; tick();
    in_valid = 0; out_ready = 1; tick(); tick(); out_ready = 0;
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 400; k++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 49) == 0);
      in_instr = rand_instr();
      in_pc = 32'h1000 + 4 * k;
      tick();
    end
    idle_inputs();
    out_ready = 1;
    for (int k = 0; k < DEPTH + 1; k++) tick();
    out_ready = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_imm();
    test_full();
    test_illegal();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
